// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter.
// No logic of its own.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int PPROT_W = 3;

endpackage

// File: rtl/apb_master_arb_rr_arbiter.sv
// Purpose: round-robin find of the first set request at or after ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is taken.
module rr_arbiter #(
    parameter  int REQUESTERS = 4,
    localparam int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic [REQUESTERS-1:0] grant,
    output logic [IDX_W-1:0]      idx,
    output logic                  vld
);

    logic [2*REQUESTERS-1:0] dbl;
    logic [REQUESTERS-1:0]   rot;
    logic [IDX_W:0]          sum;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[REQUESTERS-1:0];
        vld   = |req;
        sum   = '0;
        idx   = '0;
        grant = '0;
        // rot[k] is requester (ptr+k) mod N; the lowest set k wins
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (IDX_W+1)'(k);
            end
        end
        if (sum >= (IDX_W+1)'(REQUESTERS)) begin
            sum = sum - (IDX_W+1)'(REQUESTERS);
        end
        idx        = sum[IDX_W-1:0];
        grant[idx] = vld;
    end

endmodule

// File: rtl/apb_master_arb.sv
// Purpose: shares one APB4 master port between REQUESTERS ports, round-robin.
// Latency: req -> PSEL 1 cycle, PENABLE 2, ack_o 3 with zero wait states.
// Backpressure: PREADY low stretches ACCESS; requesters hold req_i until ack_o.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int PADDR_SIZE = 8,
    parameter int PDATA_SIZE = 8,
    parameter int REQUESTERS = 4
) (
    input  logic                                     PCLK,
    input  logic                                     PRESETn,
    input  logic [REQUESTERS-1:0]                    req_i,
    input  logic [REQUESTERS-1:0][PADDR_SIZE-1:0]    req_addr_i,
    input  logic [REQUESTERS-1:0]                    req_write_i,
    input  logic [REQUESTERS-1:0][PDATA_SIZE-1:0]    req_wdata_i,
    input  logic [REQUESTERS-1:0][PDATA_SIZE/8-1:0]  req_strb_i,
    input  logic [REQUESTERS-1:0][PPROT_W-1:0]       req_prot_i,
    output logic [REQUESTERS-1:0]                    ack_o,
    output logic [PDATA_SIZE-1:0]                    rdata_o,
    output logic                                     err_o,
    output logic                                     PSEL,
    output logic                                     PENABLE,
    output logic [PADDR_SIZE-1:0]                    PADDR,
    output logic                                     PWRITE,
    output logic [PDATA_SIZE-1:0]                    PWDATA,
    output logic [PDATA_SIZE/8-1:0]                  PSTRB,
    output logic [PPROT_W-1:0]                       PPROT,
    input  logic [PDATA_SIZE-1:0]                    PRDATA,
    input  logic                                     PREADY,
    input  logic                                     PSLVERR
);

    localparam int IDX_W = $clog2(REQUESTERS);

    apb_state_t             state, state_nxt;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       arb_idx;
    logic [REQUESTERS-1:0]  gnt_oh;
    logic [REQUESTERS-1:0]  arb_req;
    logic [REQUESTERS-1:0]  arb_grant;
    logic                   arb_vld;
    logic                   done;
    logic                   load;

    assign done = (state == ACCESS) && PREADY;

    // The requester just served (or being acked) must not win again on a stale req_i
    assign arb_req = req_i & ~ack_o & ~(done ? gnt_oh : '0);
    assign load    = arb_vld && ((state == IDLE) || done);

    rr_arbiter #(
        .REQUESTERS (REQUESTERS)
    ) u_rr (
        .req   (arb_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .vld   (arb_vld)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done) state_nxt = load ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        PSEL    = (state != IDLE);
        PENABLE = (state == ACCESS);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ptr     <= '0;
            gnt_oh  <= '0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            PPROT   <= '0;
            ack_o   <= '0;
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else begin
            ack_o <= '0;
            if (load) begin
                gnt_oh <= arb_grant;
                PADDR  <= req_addr_i[arb_idx];
                PWRITE <= req_write_i[arb_idx];
                PWDATA <= req_wdata_i[arb_idx];
                PSTRB  <= req_strb_i[arb_idx];
                PPROT  <= req_prot_i[arb_idx];
                ptr    <= (arb_idx == IDX_W'(REQUESTERS - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (done) begin
                ack_o   <= gnt_oh;
                rdata_o <= PWRITE ? '0 : PRDATA;
                err_o   <= PSLVERR;
            end
        end
    end

endmodule
